gate_vector_sequencer: RTL and testbench

- Upstream stimulus-and-check stage for basic_gates.
- Drives the a/b inputs of basic_gates through a fixed 14-vector sequence, holding each vector for a programmable number of cycles.
- Samples the eight gate outputs at the end of each hold and compares them against the expected truth table.
- Reports per-vector mismatches, a saturating error count and the index of the first failing vector, so gate regression can run synthesised on hardware without a simulator bench.

---
 rtl/gate_seq_pkg.sv | 45 ++++
 rtl/gate_vector_sequencer_if.sv | 27 ++
 rtl/gate_vector_sequencer.sv | 92 +++++++++
 tb/tb_gate_vector_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the basic_gates stimulus/check sequencer:
// state encoding, the fixed vector ROM and the gate truth-table function.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } seq_state_t;

  localparam int NUM_VEC = 14;
  localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

  // Entry 0 sits in the least significant slot; each entry is {a,b}.
  localparam logic [NUM_VEC-1:0][1:0] VEC_ROM = {
    2'b11, 2'b00, 2'b11, 2'b00,
    2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
    2'b11, 2'b10, 2'b01, 2'b00
  };

  localparam int BIT_AND   = 7;
  localparam int BIT_OR    = 6;
  localparam int BIT_XOR   = 5;
  localparam int BIT_NAND  = 4;
  localparam int BIT_NOR   = 3;
  localparam int BIT_XNOR  = 2;
  localparam int BIT_NOT_A = 1;
  localparam int BIT_NOT_B = 0;

  function automatic logic [7:0] gate_expected(input logic a, input logic b);
    logic [7:0] r;
    r            = '0;
    r[BIT_AND]   = a & b;
    r[BIT_OR]    = a | b;
    r[BIT_XOR]   = a ^ b;
    r[BIT_NAND]  = ~(a & b);
    r[BIT_NOR]   = ~(a | b);
    r[BIT_XNOR]  = ~(a ^ b);
    r[BIT_NOT_A] = ~a;
    r[BIT_NOT_B] = ~b;
    return r;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Connection bundle between the sequencer (master) and the gate harness
// (slave): run control, gate stimulus/response and check results.
interface gate_vector_sequencer_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic [7:0]       res;
  logic             busy;
  logic             done;
  logic             sample_valid;
  logic [3:0]       vec_idx;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       first_fail_idx;

  modport master (
    input  start, res,
    output a, b, busy, done, sample_valid, vec_idx, mismatch, err_count, first_fail_idx
  );

  modport slave (
    output start, res,
    input  a, b, busy, done, sample_valid, vec_idx, mismatch, err_count, first_fail_idx
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Walks basic_gates through the 14-entry vector ROM, holding each vector
// HOLD_CYCLES cycles, then checks the eight gate outputs against the truth table.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset; a/b = ROM[0]; waiting for start
//   ST_DRIVE  | vector vec_idx applied, hold counter running
//   ST_SAMPLE | one cycle; sample_valid/mismatch report the vector just held
//   ST_DONE   | run complete; results held until start or rst
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  gate_vector_sequencer_if.master bus
);

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  seq_state_t state;
  logic [7:0] hold_cnt;
  logic [3:0] next_idx;
  logic       res_bad;

  assign next_idx = bus.vec_idx + 4'd1;
  // Judged on the last DRIVE cycle so the registered mismatch lands with sample_valid.
  assign res_bad  = (bus.res != gate_expected(bus.a, bus.b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      hold_cnt           <= 8'd0;
      bus.a              <= 1'b0;
      bus.b              <= 1'b0;
      bus.vec_idx        <= 4'd0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.sample_valid   <= 1'b0;
      bus.mismatch       <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail_idx <= 4'd0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.mismatch     <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state              <= ST_DRIVE;
            {bus.a, bus.b}     <= VEC_ROM[0];
            bus.vec_idx        <= 4'd0;
            hold_cnt           <= 8'd0;
            bus.err_count      <= '0;
            bus.first_fail_idx <= 4'd0;
            bus.busy           <= 1'b1;
            bus.done           <= 1'b0;
          end
        end
        ST_DRIVE: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state            <= ST_SAMPLE;
            bus.sample_valid <= 1'b1;
            bus.mismatch     <= res_bad;
            if (res_bad) begin
              if (bus.err_count != ERR_MAX) bus.err_count <= bus.err_count + ERR_ONE;
              if (bus.err_count == '0) bus.first_fail_idx <= bus.vec_idx;
            end
          end
        end
        ST_SAMPLE: begin
          if (bus.vec_idx == LAST_VEC) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state          <= ST_DRIVE;
            bus.vec_idx    <= next_idx;
            {bus.a, bus.b} <= VEC_ROM[next_idx];
            hold_cnt       <= 8'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomised bench for gate_vector_sequencer: two instances (long hold / wide
// counter and single-cycle hold / 2-bit counter) checked every cycle against a timeline model.
module tb_gate_vector_sequencer;

  localparam int NV = 14;
  localparam int H0 = 10;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  gate_vector_sequencer_if #(.ERR_W(8)) bus0 ();
  gate_vector_sequencer_if #(.ERR_W(2)) bus1 ();

  gate_vector_sequencer #(.HOLD_CYCLES(H0), .ERR_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_vector_sequencer #(.HOLD_CYCLES(H1), .ERR_W(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;
  int tk = 0;

  int hold_of [2];
  int emax    [2];
  bit [1:0] rom [NV];

  // Model: phase 0 idle, 1 running (k cycles since first DRIVE), 2 finished.
  int m_st [2];
  int m_k  [2];
  int m_err[2];
  int m_ffi[2];
  bit m_mm [2];

  int         mode [2];
  logic [7:0] res_v[2];
  int start_tick[2];
  int done_tick [2];
  int sv_cnt    [2];
  int mm_cnt    [2];
  int done_cnt  [2];

  function automatic logic [7:0] truth(logic a, logic b);
    return {a & b, a | b, a ^ b, ~(a & b), ~(a | b), ~(a ^ b), ~a, ~b};
  endfunction

  // Emulates basic_gates, optionally broken: 1 xor stuck-0, 2 all-zero, 3 random corruption.
  function automatic logic [7:0] make_res(int md, logic a, logic b);
    logic [7:0] g;
    g = truth(a, b);
    case (md)
      1: g[5] = 1'b0;
      2: g = 8'h00;
      3: if ($urandom_range(3) == 0) g = g ^ 8'($urandom_range(1, 255));
      default: ;
    endcase
    return g;
  endfunction

  task automatic cmp(string nm, int n, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s dut%0d tick %0d: got %0d expected %0d", nm, n, tk, got, want);
    end
  endtask

  task automatic adv(int n);
    int h, i, ph;
    h = hold_of[n];
    m_mm[n] = 1'b0;
    if (rst) begin
      m_st[n] = 0; m_k[n] = 0; m_err[n] = 0; m_ffi[n] = 0;
    end else if (m_st[n] != 1 && start) begin
      m_st[n] = 1; m_k[n] = 0; m_err[n] = 0; m_ffi[n] = 0;
      start_tick[n] = tk + 1;
      done_tick[n]  = -1;
    end else if (m_st[n] == 1) begin
      i  = m_k[n] / (h + 1);
      ph = m_k[n] % (h + 1);
      if (ph == h - 1) begin
        m_mm[n] = (res_v[n] != truth(rom[i][1], rom[i][0]));
        if (m_mm[n]) begin
          if (m_err[n] == 0) m_ffi[n] = i;
          if (m_err[n] < emax[n]) m_err[n]++;
        end
      end
      m_k[n]++;
      if (m_k[n] == NV * (h + 1)) m_st[n] = 2;
    end
  endtask

  task automatic check(int n, int a, int b, int idx, int busy, int done, int sv, int mm,
                       int err, int ffi);
    int h, i, ph, ea, eb, ei, ebusy, edone, esv, emm;
    h = hold_of[n];
    ea = 0; eb = 0; ei = 0; ebusy = 0; edone = 0; esv = 0; emm = 0;
    if (m_st[n] == 1) begin
      i  = m_k[n] / (h + 1);
      ph = m_k[n] % (h + 1);
      ea = rom[i][1]; eb = rom[i][0]; ei = i; ebusy = 1;
      esv = (ph == h) ? 1 : 0;
      emm = esv ? int'(m_mm[n]) : 0;
    end else if (m_st[n] == 2) begin
      ea = 1; eb = 1; ei = NV - 1; edone = 1;
    end
    cmp("a", n, a, ea);
    cmp("b", n, b, eb);
    cmp("vec_idx", n, idx, ei);
    cmp("busy", n, busy, ebusy);
    cmp("done", n, done, edone);
    cmp("sample_valid", n, sv, esv);
    cmp("mismatch", n, mm, emm);
    if (!esv) cmp("err_count", n, err, m_err[n]);
    if (!esv && m_err[n] != 0) cmp("first_fail_idx", n, ffi, m_ffi[n]);
    if (sv != 0) sv_cnt[n]++;
    if (mm != 0) mm_cnt[n]++;
    if (done != 0) begin
      done_cnt[n]++;
      if (done_tick[n] < 0 && start_tick[n] >= 0) done_tick[n] = tk;
    end
  endtask

  task automatic tick();
    bus0.start = start;
    bus1.start = start;
    res_v[0] = make_res(mode[0], bus0.a, bus0.b);
    res_v[1] = make_res(mode[1], bus1.a, bus1.b);
    bus0.res = res_v[0];
    bus1.res = res_v[1];
    adv(0);
    adv(1);
    @(posedge clk);
    tk++;
    @(negedge clk);
    check(0, bus0.a, bus0.b, bus0.vec_idx, bus0.busy, bus0.done, bus0.sample_valid,
          bus0.mismatch, bus0.err_count, bus0.first_fail_idx);
    check(1, bus1.a, bus1.b, bus1.vec_idx, bus1.busy, bus1.done, bus1.sample_valid,
          bus1.mismatch, bus1.err_count, bus1.first_fail_idx);
  endtask

  task automatic clear_counts();
    for (int n = 0; n < 2; n++) begin
      sv_cnt[n] = 0; mm_cnt[n] = 0; done_cnt[n] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    hold_of = '{H0, H1};
    emax    = '{255, 3};
    rom     = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01,
                2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
    for (int n = 0; n < 2; n++) begin
      m_st[n] = 0; m_k[n] = 0; m_err[n] = 0; m_ffi[n] = 0; m_mm[n] = 1'b0;
      mode[n] = 0; start_tick[n] = -1; done_tick[n] = -1;
    end
    clear_counts();

    // Reset, then idle.
    rst = 1'b1;
    repeat (2) tick();
    cmp("reset_busy", 0, bus0.busy, 0);
    cmp("reset_err", 0, bus0.err_count, 0);
    cmp("reset_vec", 1, bus1.vec_idx, 0);
    rst = 1'b0;
    tick();

    // Clean run on both instances.
    clear_counts();
    pulse_start();
    repeat (160) tick();
    cmp("run_length", 0, done_tick[0] - start_tick[0], 154);
    cmp("run_length", 1, done_tick[1] - start_tick[1], 28);
    cmp("clean_samples", 0, sv_cnt[0], 14);
    cmp("clean_samples", 1, sv_cnt[1], 14);
    cmp("clean_mismatches", 0, mm_cnt[0], 0);
    cmp("clean_err", 0, bus0.err_count, 0);
    cmp("final_a", 0, bus0.a, 1);
    cmp("final_b", 0, bus0.b, 1);

    // xor stuck-at-0 on dut0, all-zero response on the 2-bit-counter dut1.
    mode = '{1, 2};
    clear_counts();
    pulse_start();
    repeat (160) tick();
    cmp("xor_err", 0, bus0.err_count, 8);
    cmp("xor_first_fail", 0, bus0.first_fail_idx, 1);
    cmp("xor_model_err", 0, m_err[0], 8);
    cmp("zero_err_sat", 1, bus1.err_count, 3);
    cmp("zero_first_fail", 1, bus1.first_fail_idx, 0);
    cmp("zero_mismatches", 1, mm_cnt[1], 14);

    // Reset during the SAMPLE cycle of vector 6, then a clean rerun.
    mode = '{0, 0};
    pulse_start();
    for (int c = 0; c < 200 && !(bus0.sample_valid === 1'b1 && bus0.vec_idx == 4'd6); c++) tick();
    cmp("reach_v6_sample", 0, bus0.vec_idx, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("midrun_rst_busy", 0, bus0.busy, 0);
    cmp("midrun_rst_vec", 0, bus0.vec_idx, 0);
    cmp("midrun_rst_sv", 0, bus0.sample_valid, 0);
    pulse_start();
    repeat (160) tick();
    cmp("rerun_err", 0, bus0.err_count, 0);
    cmp("rerun_done", 0, bus0.done, 1);

    // start held high: back-to-back runs, one done cycle between them.
    mode = '{3, 3};
    clear_counts();
    start = 1'b1;
    repeat (330) tick();
    start = 1'b0;
    cmp("held_start_done_cycles", 0, done_cnt[0], 2);
    cmp("held_start_done_cycles", 1, done_cnt[1], 11);
    repeat (160) tick();

    // Random start / reset / fault stimulus.
    for (int c = 0; c < 800; c++) begin
      start = ($urandom_range(19) == 0);
      rst   = ($urandom_range(299) == 0);
      if ($urandom_range(49) == 0) mode[0] = ($urandom_range(2) == 2) ? 3 : int'($urandom_range(1));
      if ($urandom_range(49) == 0) mode[1] = ($urandom_range(2) == 2) ? 3 : int'($urandom_range(1));
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
